// File: rtl/clink_uart_cmd_ctrl_if.sv
// Command/response bundle between the AXI register logic
// and the Camera Link serial command controller.
interface clink_uart_cmd_ctrl_if #(
  parameter int MAX_BYTES = 16,
  parameter int LEN_W     = 5
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [8*MAX_BYTES-1:0] cmd_data;
  logic [LEN_W-1:0]       cmd_len;
  logic [7:0]             rsp_data;
  logic                   rsp_valid;
  logic                   done;
  logic [1:0]             status;
  logic                   busy;

  modport master (
    output cmd_valid, cmd_data, cmd_len,
    input  cmd_ready, rsp_data, rsp_valid,
    input  done, status, busy
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_len,
    output cmd_ready, rsp_data, rsp_valid,
    output done, status, busy
  );
endinterface

// File: rtl/clink_uart_cmd_ctrl.sv
// Camera Link serial command sequencer: sends one command 8N1,
// then collects the reply until ACK/NAK or timeout.
module clink_uart_cmd_ctrl #(
  parameter int         CLK_DIV        = 868,
  parameter int         MAX_BYTES      = 16,
  parameter int         LEN_W          = 5,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15,
  parameter int         TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  clink_uart_cmd_ctrl_if.slave  bus,
  output logic                  tx_serial,
  input  logic                  rx_serial
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW    = 8 * MAX_BYTES;

  localparam logic [DIV_W-1:0] DIV_M1  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAXB    = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE, LOAD, TX_BYTE, RX_WAIT, FINISH
  } state_e;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] byte_q, byte_d;
  logic [3:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tx_q, tx_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [1:0]       status_q, status_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic [2:0]       sync_q;
  rx_e              rx_q, rx_d;
  logic [DIV_W-1:0] rcnt_q, rcnt_d;
  logic [2:0]       rbit_q, rbit_d;
  logic [7:0]       rsh_q, rsh_d;
  logic             rx_byte;
  logic             rx_s, fall;
  logic [9:0]       frame;

  assign rx_s  = sync_q[1];
  assign fall  = sync_q[2] & ~sync_q[1];
  assign frame = {1'b1, data_q[7:0], 1'b0};

  // Receiver runs only in RX_WAIT; elsewhere it is held idle
  always_comb begin
    rx_d    = rx_q;
    rcnt_d  = rcnt_q;
    rbit_d  = rbit_q;
    rsh_d   = rsh_q;
    rx_byte = 1'b0;
    if (state_q != RX_WAIT) begin
      rx_d   = R_IDLE;
      rcnt_d = '0;
      rbit_d = '0;
    end else begin
      unique case (rx_q)
        R_IDLE: begin
          if (fall) begin
            rx_d   = R_START;
            rcnt_d = '0;
          end
        end
        R_START: begin
          if (rcnt_q == HALF_M1) begin
            rcnt_d = '0;
            rbit_d = '0;
            rx_d   = rx_s ? R_IDLE : R_DATA;
          end else begin
            rcnt_d = rcnt_q + DIV_W'(1);
          end
        end
        R_DATA: begin
          if (rcnt_q == DIV_M1) begin
            rcnt_d = '0;
            rsh_d  = {rx_s, rsh_q[7:1]};
            rbit_d = rbit_q + 3'd1;
            if (rbit_q == 3'd7) rx_d = R_STOP;
          end else begin
            rcnt_d = rcnt_q + DIV_W'(1);
          end
        end
        R_STOP: begin
          if (rcnt_q == DIV_M1) begin
            rcnt_d  = '0;
            rx_d    = R_IDLE;
            rx_byte = rx_s;
          end else begin
            rcnt_d = rcnt_q + DIV_W'(1);
          end
        end
        default: rx_d = R_IDLE;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    len_d       = len_q;
    byte_d      = byte_q;
    bit_d       = bit_q;
    div_d       = div_q;
    tx_d        = 1'b1;
    to_d        = to_q;
    status_d    = status_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          data_d  = bus.cmd_data;
          len_d   = bus.cmd_len;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (len_q == '0 || len_q > MAXB) begin
          status_d = 2'b10;
          state_d  = FINISH;
        end else begin
          byte_d  = '0;
          bit_d   = '0;
          div_d   = '0;
          state_d = TX_BYTE;
        end
      end
      TX_BYTE: begin
        tx_d = frame[bit_q];
        if (div_q == DIV_M1) begin
          div_d = '0;
          if (bit_q == 4'd9) begin
            bit_d  = '0;
            data_d = data_q >> 8;
            byte_d = byte_q + LEN_W'(1);
            if (byte_q == len_q - LEN_W'(1)) begin
              to_d    = '0;
              state_d = RX_WAIT;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      RX_WAIT: begin
        to_d = to_q + TO_W'(1);
        // A byte landing on the timeout cycle wins over the timeout
        if (rx_byte) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rsh_q;
          to_d        = '0;
          if (rsh_q == ACK_BYTE) begin
            status_d = 2'b00;
            state_d  = FINISH;
          end else if (rsh_q == NAK_BYTE) begin
            status_d = 2'b11;
            state_d  = FINISH;
          end
        end else if (to_q == TO_M1) begin
          status_d = 2'b01;
          state_d  = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= IDLE;
      data_q      <= '0;
      len_q       <= '0;
      byte_q      <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      tx_q        <= 1'b1;
      to_q        <= '0;
      status_q    <= 2'b00;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      sync_q      <= 3'b111;
      rx_q        <= R_IDLE;
      rcnt_q      <= '0;
      rbit_q      <= '0;
      rsh_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      len_q       <= len_d;
      byte_q      <= byte_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      tx_q        <= tx_d;
      to_q        <= to_d;
      status_q    <= status_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      sync_q      <= {sync_q[1:0], rx_serial};
      rx_q        <= rx_d;
      rcnt_q      <= rcnt_d;
      rbit_q      <= rbit_d;
      rsh_q       <= rsh_d;
    end
  end

  assign tx_serial     = tx_q;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FINISH);
  assign bus.status    = status_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_clink_uart_cmd_ctrl.sv
// Randomized scoreboard bench for clink_uart_cmd_ctrl with a
// camera-side UART model and a tx-line decoder.
module tb_clink_uart_cmd_ctrl;
  localparam int D   = 8;
  localparam int MB  = 16;
  localparam int LW  = 5;
  localparam int T   = 200;
  // falling edge of a reply byte to done: 2 sync flops,
  // half-bit start check, 9 bit times, one register stage
  localparam int LAT = D / 2 + 9 * D + 3;

  typedef struct { logic [7:0] d; int t; } tx_t;
  typedef struct { logic [1:0] st; int lo; int hi; } done_t;

  logic clk = 0;
  logic rst_n = 0;
  logic rx = 1;
  logic tx;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   rst_gen = 0;

  tx_t        exp_tx[$];
  logic [7:0] exp_rsp[$];
  done_t      exp_done[$];

  clink_uart_cmd_ctrl_if #(.MAX_BYTES(MB), .LEN_W(LW)) bus ();

  clink_uart_cmd_ctrl #(
    .CLK_DIV(D), .MAX_BYTES(MB), .LEN_W(LW),
    .ACK_BYTE(8'h06), .NAK_BYTE(8'h15),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(rst_n),
    .bus(bus),
    .tx_serial(tx),
    .rx_serial(rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic fail_ev(input string nm, input int act);
    n_chk++;
    $display("FAIL %s: got %0h want none", nm, act);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus.busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) fail_ev("idle_wait_expired", k);
    @(posedge clk); #1;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (D) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (D) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (D) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic issue(input int len, input logic [127:0] d,
                       output int t);
    t = cyc;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    bus.cmd_data  = d;
    chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 1);
    if (len >= 1 && len <= MB)
      for (int i = 0; i < len; i++)
        exp_tx.push_back('{d[8*i +: 8], t + 3 + 10 * D * i});
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("busy_after_hs", {31'd0, bus.busy}, 1);
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] rnd_plain();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (b == 8'h06 || b == 8'h15) b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  // rsp monitor
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (exp_rsp.size() == 0) fail_ev("rsp_extra", bus.rsp_data);
      else chk("rsp_data", bus.rsp_data, exp_rsp.pop_front());
    end
  end

  // done monitor
  always @(negedge clk) begin
    done_t e;
    if (rst_n && bus.done) begin
      if (exp_done.size() == 0) fail_ev("done_extra", bus.status);
      else begin
        e = exp_done.pop_front();
        chk("done_status", bus.status, e.st);
        n_chk++;
        if (cyc >= e.lo && cyc <= e.hi) n_pass++;
        else $display("FAIL done_cycle: got %0d want %0d..%0d",
                      cyc, e.lo, e.hi);
      end
    end
  end

  // tx line decoder
  initial begin : txmon
    logic prev;
    logic [7:0] b;
    logic sb;
    int s, g;
    tx_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !tx) begin
        s = cyc;
        g = rst_gen;
        repeat (D / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (D) @(negedge clk);
          b[i] = tx;
        end
        repeat (D) @(negedge clk);
        sb = tx;
        if (g == rst_gen) begin
          if (exp_tx.size() == 0) fail_ev("tx_extra", b);
          else begin
            e = exp_tx.pop_front();
            chk("tx_start_cycle", s, e.t);
            chk("tx_byte", b, e.d);
            chk("tx_stop", {31'd0, sb}, 1);
          end
        end
        prev = 1'b1;
      end else begin
        prev = tx;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin : stim
    int t, r0, len, nb;
    logic [127:0] d;
    logic [7:0] b;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 1);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_status", {30'd0, bus.status}, 0);
    chk("rst_rsp_data", {24'd0, bus.rsp_data}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // two-byte command, reply 0x41 then ACK
    issue(2, 128'h3F52, t);
    r0 = t + 2 + 2 * 10 * D;
    wait_cyc(r0 + 5);
    exp_rsp.push_back(8'h41);
    uart_send(8'h41, 1'b1);
    exp_rsp.push_back(8'h06);
    exp_done.push_back('{2'b00, cyc + LAT - 4, cyc + LAT + 4});
    uart_send(8'h06, 1'b1);
    wait_idle();

    // illegal lengths
    for (int k = 0; k < 3; k++) begin
      len = (k == 0) ? 0 : (k == 1) ? MB + 1 : $urandom_range(MB + 2, 31);
      exp_done.push_back('{2'b10, cyc + 2, cyc + 2});
      issue(len, rnd_data(), t);
      repeat (4) begin
        @(negedge clk);
        chk("tx_idle_badlen", {31'd0, tx}, 1);
      end
      wait_idle();
    end

    // NAK reply
    issue(3, rnd_data(), t);
    r0 = t + 2 + 3 * 10 * D;
    wait_cyc(r0 + 3);
    exp_rsp.push_back(8'h15);
    exp_done.push_back('{2'b11, cyc + LAT - 4, cyc + LAT + 4});
    uart_send(8'h15, 1'b1);
    wait_idle();

    // silent camera with a short glitch: plain timeout
    issue(1, rnd_data(), t);
    r0 = t + 2 + 10 * D;
    exp_done.push_back('{2'b01, r0 + T, r0 + T});
    wait_cyc(r0 + 20);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    wait_idle();

    // ACK completing on the timeout cycle wins
    issue(1, rnd_data(), t);
    r0 = t + 2 + 10 * D;
    exp_done.push_back('{2'b00, r0 + T, r0 + T});
    exp_rsp.push_back(8'h06);
    wait_cyc(r0 + T - LAT);
    uart_send(8'h06, 1'b1);
    wait_idle();

    // ACK one cycle too late: timeout, byte ignored
    issue(1, rnd_data(), t);
    r0 = t + 2 + 10 * D;
    exp_done.push_back('{2'b01, r0 + T, r0 + T});
    wait_cyc(r0 + T - LAT + 1);
    uart_send(8'h06, 1'b1);
    wait_idle();

    // framing error then good ACK
    issue(1, rnd_data(), t);
    r0 = t + 2 + 10 * D;
    wait_cyc(r0 + 4);
    uart_send(8'hA5, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    exp_rsp.push_back(8'h06);
    exp_done.push_back('{2'b00, cyc + LAT - 4, cyc + LAT + 4});
    uart_send(8'h06, 1'b1);
    wait_idle();

    // randomized transactions, line noise during TX ignored
    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(1, 4);
      d = rnd_data();
      issue(len, d, t);
      r0 = t + 2 + len * 10 * D;
      if (len >= 2) begin
        wait_cyc(t + 5);
        uart_send(8'($urandom_range(0, 255)), 1'b1);
      end
      wait_cyc(r0 + $urandom_range(1, 30));
      nb = $urandom_range(0, 2);
      for (int i = 0; i < nb; i++) begin
        b = rnd_plain();
        exp_rsp.push_back(b);
        uart_send(b, 1'b1);
        repeat ($urandom_range(0, 10)) @(posedge clk);
        #1;
      end
      b = $urandom_range(0, 1) ? 8'h06 : 8'h15;
      exp_rsp.push_back(b);
      exp_done.push_back('{(b == 8'h06) ? 2'b00 : 2'b11,
                           cyc + LAT - 4, cyc + LAT + 4});
      uart_send(b, 1'b1);
      wait_idle();
    end

    // reset during the third transmitted byte
    d = rnd_data();
    issue(4, d, t);
    wait_cyc(t + 3 + 2 * 10 * D + 2);
    rst_n = 1'b0;
    rst_gen++;
    #1;
    chk("rst_mid_tx", {31'd0, tx}, 1);
    chk("rst_mid_busy", {31'd0, bus.busy}, 0);
    chk("rst_mid_ready", {31'd0, bus.cmd_ready}, 1);
    chk("rst_mid_status", {30'd0, bus.status}, 0);
    exp_tx.delete();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(t + 400);
    d = rnd_data();
    issue(2, d, t);
    r0 = t + 2 + 2 * 10 * D;
    wait_cyc(r0 + 2);
    exp_rsp.push_back(8'h06);
    exp_done.push_back('{2'b00, cyc + LAT - 4, cyc + LAT + 4});
    uart_send(8'h06, 1'b1);
    wait_idle();
    repeat (20) @(posedge clk);

    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
